img_frame_ctrl: RTL

Frame-level sequencer for the ImgProcess pixel datapath. Free-runs VGA raster counters (800x525 total, 640x480 active) and generates sync and blank. Gates `i_is_new_read` into ImgProcess so that processing starts and stops only on frame boundaries. Latches the processing mode once per frame and tracks the datapath latency to flag valid output pixels.

---
 rtl/img_frame_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/img_frame_ctrl.sv
// rtl/img_frame_ctrl.sv - VGA raster sequencer gating ImgProcess on frame boundaries
module img_frame_ctrl #(
    parameter logic [10:0] H_TOTAL      = 11'd800,
    parameter logic [10:0] V_TOTAL      = 11'd525,
    parameter logic [10:0] H_ACTIVE     = 11'd640,
    parameter logic [10:0] V_ACTIVE     = 11'd480,
    parameter logic [10:0] H_SYNC_START = 11'd656,
    parameter logic [10:0] H_SYNC_END   = 11'd752,
    parameter logic [10:0] V_SYNC_START = 11'd490,
    parameter logic [10:0] V_SYNC_END   = 11'd492,
    parameter int          PROC_LATENCY = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [1:0]  i_mode,
    output logic [1:0]  o_proc_mode,
    output logic        o_is_new_read,
    output logic        o_out_valid,
    output logic [10:0] o_h_cnt,
    output logic [10:0] o_v_cnt,
    output logic        o_hsync_n,
    output logic        o_vsync_n,
    output logic        o_blank_n,
    output logic        o_frame_done,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;

    localparam int DW = $clog2(PROC_LATENCY + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(PROC_LATENCY);

    state_t                  state;
    logic                    stop_pend;
    logic [DW-1:0]           drain_cnt;
    logic [PROC_LATENCY-1:0] lat_sr;
    logic                    h_last;
    logic                    v_last;
    logic                    eof;
    logic                    active;

    assign h_last = (o_h_cnt == H_TOTAL - 11'd1);
    assign v_last = (o_v_cnt == V_TOTAL - 11'd1);
    assign eof    = h_last && v_last;
    assign active = (o_h_cnt < H_ACTIVE) && (o_v_cnt < V_ACTIVE);

    assign o_blank_n     = active;
    assign o_hsync_n     = !((o_h_cnt >= H_SYNC_START) && (o_h_cnt < H_SYNC_END));
    assign o_vsync_n     = !((o_v_cnt >= V_SYNC_START) && (o_v_cnt < V_SYNC_END));
    assign o_is_new_read = (state == RUN) && active;
    assign o_frame_done  = (state == RUN) && eof;
    assign o_busy        = (state != IDLE);
    assign o_out_valid   = lat_sr[PROC_LATENCY-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_h_cnt     <= 11'd0;
            o_v_cnt     <= 11'd0;
            state       <= IDLE;
            stop_pend   <= 1'b0;
            drain_cnt   <= '0;
            o_proc_mode <= 2'd0;
        end else begin
            o_h_cnt <= h_last ? 11'd0 : o_h_cnt + 11'd1;
            if (h_last) begin
                o_v_cnt <= v_last ? 11'd0 : o_v_cnt + 11'd1;
            end

            case (state)
                IDLE: begin
                    if (!i_stop && i_start) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (i_stop) begin
                        state <= IDLE;
                    end else if (eof) begin
                        state       <= RUN;
                        o_proc_mode <= i_mode;
                    end
                end
                RUN: begin
                    // a stop is only honoured at the frame boundary, never mid-frame
                    if (eof) begin
                        if (stop_pend || i_stop) begin
                            state     <= DRAIN;
                            stop_pend <= 1'b0;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            o_proc_mode <= i_mode;
                        end
                    end else if (i_stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt <= DW'(1)) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (PROC_LATENCY == 1) begin : g_lat1
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) lat_sr <= '0;
                else          lat_sr <= o_is_new_read;
            end
        end else begin : g_latn
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) lat_sr <= '0;
                else          lat_sr <= {lat_sr[PROC_LATENCY-2:0], o_is_new_read};
            end
        end
    endgenerate

endmodule
